// File: rtl/alu_result_checker.sv
// alu_result_checker: checks a stream of ALU results against a reference model.
// A run starts with a start pulse that loads num_txn. Each accepted transaction
// is registered and compared one cycle later; pass/fail counters saturate.
// Optional first-failure capture is built when ALU_CHK_FIRST_FAIL_EN is defined;
// otherwise first_fail_idx/first_fail_exp are tied to zero.
module alu_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One registered transaction awaiting comparison
  typedef struct packed {
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] act;
    logic             last;
`ifdef ALU_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] idx;
`endif
  } txn_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] acc_cnt;
  logic             stg_vld;
  txn_t             stg;
  logic             xfer;
  logic             start_ok;
  logic             cmp_fail;

  // Reference ALU, all results truncated to WIDTH bits
  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a << 1;
      default: r = a >> 1;
    endcase
    return r;
  endfunction

  assign in_ready = (state == RUN) && (acc_cnt < num_reg);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state != RUN);
  assign cmp_fail = stg_vld && (stg.exp != stg.act);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave RUN in the same cycle the last comparison lands
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_txn == '0) ? DONE : RUN;
      RUN:        if (stg_vld && stg.last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Acceptance side: run length, accepted count and the compare stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_reg <= '0;
      acc_cnt <= '0;
      stg_vld <= 1'b0;
      stg     <= '0;
    end else if (start_ok) begin
      num_reg <= num_txn;
      acc_cnt <= '0;
      stg_vld <= 1'b0;
    end else begin
      stg_vld <= xfer;
      if (xfer) begin
        acc_cnt  <= acc_cnt + 1'b1;
        stg.exp  <= alu_ref(in_a, in_b, in_sel);
        stg.act  <= in_out;
        stg.last <= (acc_cnt == num_reg - 1'b1);
`ifdef ALU_CHK_FIRST_FAIL_EN
        stg.idx  <= acc_cnt;
`endif
      end
    end
  end

  // Result side: saturating pass/fail counters and sticky mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      mismatch <= 1'b0;
    end else if (start_ok) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      mismatch <= 1'b0;
    end else if (stg_vld) begin
      if (cmp_fail) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        mismatch <= 1'b1;
      end else begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

`ifdef ALU_CHK_FIRST_FAIL_EN
  // Capture index/expected value of the first failure only (mismatch still low)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_idx <= '0;
      first_fail_exp <= '0;
    end else if (start_ok) begin
      first_fail_idx <= '0;
      first_fail_exp <= '0;
    end else if (cmp_fail && !mismatch) begin
      first_fail_idx <= stg.idx;
      first_fail_exp <= stg.exp;
    end
  end
`else
  assign first_fail_idx = '0;
  assign first_fail_exp = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: the driver pushes the expected
// outcome of every transfer; a monitor pops one entry per counter increment.
module tb_alu_result_checker;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk, rst_n, start, in_valid, in_ready;
  logic [CW-1:0] num_txn, pass_cnt, fail_cnt, first_fail_idx;
  logic [W-1:0]  in_a, in_b, in_out, first_fail_exp;
  logic [2:0]    in_sel;
  logic          busy, done, mismatch;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  alu_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .in_out(in_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .busy(busy), .done(done), .mismatch(mismatch),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Used only to create correct results for the random stream
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[W-2:0], 1'b0};
      default: return {1'b0, a[W-1:1]};
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_pass"},     pass_cnt, 0);
    check({tag, "_fail"},     fail_cnt, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_ff_idx"},   first_fail_idx, 0);
    check({tag, "_ff_exp"},   first_fail_exp, 0);
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_txn = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one transaction and wait (bounded) for it to be accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                      input logic [W-1:0] o, input bit pass);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_sel = sel; in_out = o; in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(pass);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for a=%0d b=%0d sel=%0d", a, b, sel);
    end
  endtask

  // Monitor: each counter increment consumes one expected outcome
  initial begin
    logic [CW-1:0] pp, pf;
    bit e;
    pp = '0; pf = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || pass_cnt < pp || fail_cnt < pf) begin
        pp = pass_cnt; pf = fail_cnt;
      end else if (pass_cnt != pp || fail_cnt != pf) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cmp: pass=%0d fail=%0d with no transfer pending", pass_cnt, fail_cnt);
        end else begin
          e = exp_q.pop_front();
          check("txn_outcome_pass", (pass_cnt == pp + 1'b1) ? 1 : 0, e ? 1 : 0);
          check("txn_outcome_fail", (fail_cnt == pf + 1'b1) ? 1 : 0, e ? 0 : 1);
        end
        pp = pass_cnt; pf = fail_cnt;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; num_txn = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0; in_out = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // in_valid while IDLE: never ready, counters untouched
    in_a = 8'd1; in_b = 8'd1; in_sel = 3'd0; in_out = 8'd2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
    end
    check("idle_pass", pass_cnt, 0);
    check("idle_fail", fail_cnt, 0);
    in_valid = 1'b0;

    // Two passing transactions, with a start pulse mid-run that must be ignored
    start_run(2);
    send(8'd200, 8'd100, 3'd0, 8'd44, 1'b1);
    start = 1'b1; num_txn = 16'd7;
    @(posedge clk); #1 start = 1'b0;
    send(8'd5, 8'd10, 3'd1, 8'd251, 1'b1);
    @(posedge clk); @(negedge clk);
    check("r1_done", done, 1);
    check("r1_busy", busy, 0);
    check("r1_pass", pass_cnt, 2);
    check("r1_fail", fail_cnt, 0);
    check("r1_mismatch", mismatch, 0);

    // One pass then two fails; first failure is index 1 with expected 6
    start_run(3);
    send(8'd3, 8'd5, 3'd2, 8'd1, 1'b1);
    send(8'd3, 8'd5, 3'd4, 8'd7, 1'b0);
    send(8'd3, 8'd5, 3'd3, 8'd9, 1'b0);
    @(posedge clk); @(negedge clk);
    check("r2_pass", pass_cnt, 1);
    check("r2_fail", fail_cnt, 2);
    check("r2_mismatch", mismatch, 1);
    check("r2_done", done, 1);
`ifdef ALU_CHK_FIRST_FAIL_EN
    check("r2_ff_idx", first_fail_idx, 1);
    check("r2_ff_exp", first_fail_exp, 6);
`else
    check("r2_ff_idx", first_fail_idx, 0);
    check("r2_ff_exp", first_fail_exp, 0);
`endif

    // Zero-length run goes straight to DONE with cleared status
    start_run(0);
    @(negedge clk);
    check("r0_done", done, 1);
    check("r0_busy", busy, 0);
    check("r0_pass", pass_cnt, 0);
    check("r0_fail", fail_cnt, 0);
    check("r0_mismatch", mismatch, 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("r0_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // Four transfers including boundary ops, then a fifth offer is refused
    start_run(4);
    send(8'h80, 8'h00, 3'd6, 8'h00, 1'b1);
    send(8'h0F, 8'h00, 3'd5, 8'hF0, 1'b1);
    send(8'h81, 8'h00, 3'd7, 8'h40, 1'b1);
    send(8'd250, 8'd10, 3'd0, 8'd4, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    check("r4_fifth_ready", in_ready, 0);
    check("r4_busy", busy, 1);
    @(negedge clk);
    check("r4_fifth_ready2", in_ready, 0);
    check("r4_done", done, 1);
    check("r4_pass", pass_cnt, 4);
    in_valid = 1'b0;

    // Ten back-to-back correct transactions; final count lands one cycle later
    start_run(10);
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a, b;
      logic [2:0]   s;
      a = W'($urandom); b = W'($urandom); s = 3'($urandom_range(0, 7));
      send(a, b, s, model(a, b, s), 1'b1);
    end
    @(negedge clk);
    check("r10_pass_before", pass_cnt, 9);
    check("r10_done_before", done, 0);
    @(negedge clk);
    check("r10_pass", pass_cnt, 10);
    check("r10_done", done, 1);

    // Reset after two of five transfers, with one comparison still in flight
    start_run(5);
    send(8'd1, 8'd2, 3'd0, 8'd3, 1'b1);
    send(8'd9, 8'd4, 3'd1, 8'd5, 1'b1);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_busy", busy, 0);
      check("postrst_done", done, 0);
      check("postrst_pass", pass_cnt, 0);
    end
    start_run(2);
    send(8'd7, 8'd7, 3'd4, 8'd0, 1'b1);
    send(8'h55, 8'hAA, 3'd3, 8'hFF, 1'b1);
    @(posedge clk); @(negedge clk);
    check("fresh_pass", pass_cnt, 2);
    check("fresh_fail", fail_cnt, 0);
    check("fresh_done", done, 1);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
